// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch sequencer in front of the pc unit.
// The optional performance counters are enabled with the PC_SEQ_PERF_EN macro.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;
    localparam int          DEFAULT_INC_BY    = 4;

    // A target is misaligned when any bit below the stride is set.
    function automatic logic isMisaligned(input logic [31:0] addr, input logic [31:0] mask);
        return (addr & mask) != 32'd0;
    endfunction

endpackage

// File: rtl/pc_seq_perf.sv
// Saturating event counters for the fetch sequencer: completed fetch
// handshakes and redirect (flush) cycles. Only built with PC_SEQ_PERF_EN.
module pc_seq_perf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_done_i,
    input  logic        redirect_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redir_cnt_o
);

    logic [31:0] r_fetchCnt;
    logic [31:0] r_redirCnt;

    // Count completed fetch handshakes, sticking at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetchCnt <= 32'd0;
        end else if (fetch_done_i && (r_fetchCnt != 32'hFFFF_FFFF)) begin
            r_fetchCnt <= r_fetchCnt + 32'd1;
        end
    end

    // Count cycles that squash the in-flight fetch, sticking at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_redirCnt <= 32'd0;
        end else if (redirect_i && (r_redirCnt != 32'hFFFF_FFFF)) begin
            r_redirCnt <= r_redirCnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_fetchCnt;
    assign redir_cnt_o = r_redirCnt;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: the only driver of the pc unit's enable/load controls.
// Each cycle it holds, increments or loads the PC, arbitrating exception and
// branch redirects against sequential fetch, trapping misaligned branch
// targets, and supporting halt/wake. Define PC_SEQ_PERF_EN to add the
// fetch/redirect counters.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC,
    parameter int          INC_BY    = DEFAULT_INC_BY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        br_req_i,
    input  logic [31:0] br_tgt_i,
    input  logic        exc_req_i,
    input  logic        halt_i,
    input  logic        imem_rdy_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        pc_en_o,
    output logic        pc_ld_o,
    output logic [31:0] pc_ld_val_o,
    output logic        flush_o,
`ifdef PC_SEQ_PERF_EN
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redir_cnt_o
`else
    output logic        misalign_o
`endif
);

    // Mask form of the low-bit alignment check; also valid when INC_BY is 1.
    localparam logic [31:0] ALIGN_MASK = 32'(INC_BY - 1);

    seq_state_t  r_state;
    seq_state_t  w_nextState;
    logic        w_req;
    logic        w_en;
    logic        w_ld;
    logic [31:0] w_ldVal;
    logic        w_flush;
    logic        w_misalign;

    // State register; reset always restarts from the boot load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and the per-cycle hold/increment/load decision.
    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_en        = 1'b0;
        w_ld        = 1'b0;
        w_ldVal     = 32'd0;
        w_flush     = 1'b0;
        w_misalign  = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_en        = 1'b1;
                w_ld        = 1'b1;
                w_ldVal     = RESET_VEC;
                w_nextState = FETCH;
            end
            FETCH: begin
                if (exc_req_i) begin
                    w_en    = 1'b1;
                    w_ld    = 1'b1;
                    w_ldVal = TRAP_VEC;
                    w_flush = 1'b1;
                end else if (br_req_i && isMisaligned(br_tgt_i, ALIGN_MASK)) begin
                    w_en       = 1'b1;
                    w_ld       = 1'b1;
                    w_ldVal    = TRAP_VEC;
                    w_flush    = 1'b1;
                    w_misalign = 1'b1;
                end else if (br_req_i) begin
                    w_en    = 1'b1;
                    w_ld    = 1'b1;
                    w_ldVal = br_tgt_i;
                    w_flush = 1'b1;
                end else if (halt_i) begin
                    w_nextState = HALT;
                end else begin
                    w_req = 1'b1;
                    w_en  = imem_rdy_i;
                end
            end
            HALT: begin
                if (exc_req_i) begin
                    w_en        = 1'b1;
                    w_ld        = 1'b1;
                    w_ldVal     = TRAP_VEC;
                    w_flush     = 1'b1;
                    w_nextState = FETCH;
                end else if (!halt_i) begin
                    w_nextState = FETCH;
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    assign imem_req_o  = w_req      & ~rst_i;
    assign imem_addr_o = rst_i ? 32'd0 : pc_i;
    assign pc_en_o     = w_en       & ~rst_i;
    assign pc_ld_o     = w_ld       & ~rst_i;
    assign pc_ld_val_o = rst_i ? 32'd0 : w_ldVal;
    assign flush_o     = w_flush    & ~rst_i;
    assign misalign_o  = w_misalign & ~rst_i;

`ifdef PC_SEQ_PERF_EN
    logic w_fetchDone;
    assign w_fetchDone = imem_req_o & imem_rdy_i;

    pc_seq_perf u_perf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fetch_done_i (w_fetchDone),
        .redirect_i   (flush_o),
        .fetch_cnt_o  (fetch_cnt_o),
        .redir_cnt_o  (redir_cnt_o)
    );
`endif

endmodule
